// File: rtl/csr_unit_if.sv
// Execute-stage CSR port bundle: decoder controls and operands in, read-back and status out.
interface csr_unit_if #(
  parameter int DWIDTH = 32
);
  logic              csr_we;
  logic              csr_rd;
  logic [2:0]        funct3;
  logic [11:0]       csr_addr;
  logic [DWIDTH-1:0] rs1_data;
  logic [4:0]        zimm;
  logic              stall;
  logic              retire;
  logic [DWIDTH-1:0] csr_rdata;
  logic              csr_rvalid;
  logic              illegal;
  logic [DWIDTH-1:0] tohost;

  modport master (
    output csr_we, csr_rd, funct3, csr_addr, rs1_data, zimm, stall, retire,
    input  csr_rdata, csr_rvalid, illegal, tohost
  );

  modport slave (
    input  csr_we, csr_rd, funct3, csr_addr, rs1_data, zimm, stall, retire,
    output csr_rdata, csr_rvalid, illegal, tohost
  );
endinterface

// File: rtl/csr_unit.sv
// Zicsr read-modify-write unit holding tohost, mscratch and the cycle/instret counters.
// The old CSR value is registered and returned one cycle after the access edge.
module csr_unit #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 64
) (
  input logic         clk,
  input logic         rst,
  csr_unit_if.slave   bus
);
  localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  logic [DWIDTH-1:0] tohost_q, mscratch_q, rdata_q;
  logic [CWIDTH-1:0] cycle_q, instret_q;
  logic              rvalid_q, illegal_q;

  logic [DWIDTH-1:0] src, old_val, new_val;
  logic              mapped, read_only, wr_req, acc_illegal, do_write;

  always_comb begin
    src       = bus.funct3[2] ? {{(DWIDTH-5){1'b0}}, bus.zimm} : bus.rs1_data;
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    unique case (bus.csr_addr)
      ADDR_TOHOST:   old_val = tohost_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_CYCLE:    begin old_val = cycle_q[DWIDTH-1:0];        read_only = 1'b1; end
      ADDR_CYCLEH:   begin old_val = cycle_q[CWIDTH-1:DWIDTH];   read_only = 1'b1; end
      ADDR_INSTRET:  begin old_val = instret_q[DWIDTH-1:0];      read_only = 1'b1; end
      ADDR_INSTRETH: begin old_val = instret_q[CWIDTH-1:DWIDTH]; read_only = 1'b1; end
      default:       mapped = 1'b0;
    endcase

    unique case (bus.funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase

    // Set/clear with a zero rs1 field is a pure read, so it is legal even on counters.
    wr_req      = (bus.funct3[1:0] == 2'b01) || (bus.zimm != 5'd0);
    acc_illegal = !mapped || (bus.funct3[1:0] == 2'b00) || (wr_req && read_only);
    do_write    = bus.csr_we && !bus.stall && !acc_illegal && wr_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q   <= '0;
      mscratch_q <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_q + CWIDTH'(1);
      if (bus.retire) instret_q <= instret_q + CWIDTH'(1);

      // A stalled execute stage freezes the response registers as well as writes.
      if (!bus.stall) begin
        rvalid_q  <= bus.csr_we && !acc_illegal && bus.csr_rd;
        illegal_q <= bus.csr_we && acc_illegal;
        if (bus.csr_we && !acc_illegal) rdata_q <= old_val;
      end

      if (do_write) begin
        if (bus.csr_addr == ADDR_TOHOST)   tohost_q   <= new_val;
        if (bus.csr_addr == ADDR_MSCRATCH) mscratch_q <= new_val;
      end
    end
  end

  assign bus.csr_rdata  = rdata_q;
  assign bus.csr_rvalid = rvalid_q;
  assign bus.illegal    = illegal_q;
  assign bus.tohost     = tohost_q;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: each access pushes its predicted response to a queue,
// which is popped and compared once the DUT has answered.
module tb_csr_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_unit_if #(.DWIDTH(32)) bus ();
  csr_unit #(.DWIDTH(32), .CWIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        illegal;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_tohost, m_mscratch;
  logic [63:0] m_edges, m_ret, cyc_base, edges_at_base;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges <= '0;
      m_ret   <= '0;
    end else begin
      m_edges <= m_edges + 64'd1;
      if (bus.retire) m_ret <= m_ret + 64'd1;
    end
  end

  function automatic logic [63:0] cyc_now();
    return cyc_base + (m_edges - edges_at_base);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; the access occupies one rising edge.
  task automatic csr_op(input string tag, input logic rd, input logic [2:0] f3,
                        input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] zi);
    exp_t e;
    logic [31:0] src, old, nv;
    logic [63:0] c;
    logic mapped, ro, wr, ill;
    src = f3[2] ? {27'b0, zi} : rs1;
    c = cyc_now();
    mapped = 1'b1; ro = 1'b1; old = '0;
    case (addr)
      12'h51E: begin old = m_tohost;     ro = 1'b0; end
      12'h340: begin old = m_mscratch;   ro = 1'b0; end
      12'hC00: old = c[31:0];
      12'hC80: old = c[63:32];
      12'hC02: old = m_ret[31:0];
      12'hC82: old = m_ret[63:32];
      default: mapped = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    wr  = (f3[1:0] == 2'b01) || (zi != 5'd0);
    ill = !mapped || (f3[1:0] == 2'b00) || (wr && ro);
    bus.csr_we = 1'b1; bus.csr_rd = rd; bus.funct3 = f3; bus.csr_addr = addr;
    bus.rs1_data = rs1; bus.zimm = zi;
    e.rdata = old; e.rvalid = !ill && rd; e.illegal = ill;
    sb.push_back(e);
    @(posedge clk);
    if (!ill && wr) begin
      if (addr == 12'h51E) m_tohost = nv;
      if (addr == 12'h340) m_mscratch = nv;
    end
    @(negedge clk);
    bus.csr_we = 1'b0;
    e = sb.pop_front();
    chk({tag, "_rvalid"}, 64'(bus.csr_rvalid), 64'(e.rvalid));
    chk({tag, "_illegal"}, 64'(bus.illegal), 64'(e.illegal));
    if (e.rvalid) chk({tag, "_rdata"}, 64'(bus.csr_rdata), 64'(e.rdata));
    chk({tag, "_tohost"}, 64'(bus.tohost), 64'(m_tohost));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.csr_we = 1'b0; bus.csr_rd = 1'b0; bus.funct3 = 3'd0; bus.csr_addr = 12'd0;
    bus.rs1_data = '0; bus.zimm = 5'd0; bus.stall = 1'b0; bus.retire = 1'b0;
    m_tohost = '0; m_mscratch = '0; cyc_base = '0; edges_at_base = '0;

    // Reset for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_rdata", 64'(bus.csr_rdata), 64'd0);
    chk("rst_rvalid", 64'(bus.csr_rvalid), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_tohost", 64'(bus.tohost), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("cycle10_model", cyc_now(), 64'd10);
    csr_op("rd_cycle", 1'b1, 3'b010, 12'hC00, 32'h0, 5'd0);
    @(negedge clk);
    chk("rvalid_one_cycle", 64'(bus.csr_rvalid), 64'd0);

    // tohost RW then RCI
    csr_op("rw_tohost", 1'b1, 3'b001, 12'h51E, 32'h1, 5'd1);
    chk("tohost_is1", 64'(bus.tohost), 64'd1);
    csr_op("rci_tohost", 1'b1, 3'b111, 12'h51E, 32'h0, 5'd1);
    chk("tohost_is0", 64'(bus.tohost), 64'd0);

    // mscratch set with zero rs1 field, then RSI
    csr_op("rw_mscr", 1'b0, 3'b001, 12'h340, 32'hF0, 5'd2);
    csr_op("rs_x0_mscr", 1'b1, 3'b010, 12'h340, 32'hAB, 5'd0);
    csr_op("rsi_mscr", 1'b1, 3'b110, 12'h340, 32'h0, 5'h0F);
    csr_op("rd_mscr", 1'b1, 3'b010, 12'h340, 32'h0, 5'd0);
    chk("mscr_ff_model", 64'(m_mscratch), 64'hFF);

    // Illegal accesses
    csr_op("rw_cycle_ill", 1'b1, 3'b001, 12'hC00, 32'h5, 5'd1);
    @(negedge clk);
    chk("illegal_one_cycle", 64'(bus.illegal), 64'd0);
    csr_op("rd_cycle2", 1'b1, 3'b010, 12'hC00, 32'h0, 5'd0);
    csr_op("unmapped", 1'b1, 3'b010, 12'h123, 32'h0, 5'd0);
    csr_op("f3_000", 1'b1, 3'b000, 12'h340, 32'h0, 5'd0);
    csr_op("f3_100", 1'b1, 3'b100, 12'h51E, 32'h0, 5'd3);
    csr_op("rci_instret_ill", 1'b1, 3'b111, 12'hC02, 32'h0, 5'd4);
    csr_op("rc_x0_instret", 1'b1, 3'b011, 12'hC02, 32'hFFFF_FFFF, 5'd0);

    // Stall holds outputs and blocks the write; retire pulses continue
    csr_op("rw_tohost2", 1'b0, 3'b001, 12'h51E, 32'h1234, 5'd5);
    csr_op("rd_tohost", 1'b1, 3'b010, 12'h51E, 32'h0, 5'd0);
    bus.stall = 1'b1; bus.retire = 1'b1;
    bus.csr_we = 1'b1; bus.csr_rd = 1'b1; bus.funct3 = 3'b010; bus.csr_addr = 12'h51E;
    bus.rs1_data = 32'h55; bus.zimm = 5'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_tohost", 64'(bus.tohost), 64'h1234);
      chk("stall_rvalid", 64'(bus.csr_rvalid), 64'd1);
      chk("stall_rdata", 64'(bus.csr_rdata), 64'h1234);
      chk("stall_illegal", 64'(bus.illegal), 64'd0);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    bus.csr_we = 1'b0; bus.retire = 1'b0;
    m_tohost = 32'h1234 | 32'h55;
    chk("unstall_rdata", 64'(bus.csr_rdata), 64'h1234);
    chk("unstall_tohost", 64'(bus.tohost), 64'(m_tohost));
    csr_op("rd_instret", 1'b1, 3'b010, 12'hC02, 32'h0, 5'd0);
    chk("instret5_model", m_ret, 64'd5);
    csr_op("rd_instreth", 1'b1, 3'b010, 12'hC82, 32'h0, 5'd0);

    // Low-half carry into cycleh
    csr_op("rd_cycleh0", 1'b1, 3'b010, 12'hC80, 32'h0, 5'd0);
    dut.cycle_q = 64'h0000_0000_FFFF_FFFD;
    cyc_base = 64'h0000_0000_FFFF_FFFD;
    edges_at_base = m_edges;
    csr_op("rd_cycle_pre", 1'b1, 3'b010, 12'hC00, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    csr_op("rd_cycleh1", 1'b1, 3'b010, 12'hC80, 32'h0, 5'd0);
    chk("cycleh_carry_model", cyc_now() >> 32, 64'd1);
    csr_op("rd_cycle_post", 1'b1, 3'b010, 12'hC00, 32'h0, 5'd0);

    // Async reset lands in the middle of a write
    bus.csr_we = 1'b1; bus.csr_rd = 1'b1; bus.funct3 = 3'b001; bus.csr_addr = 12'h51E;
    bus.rs1_data = 32'h77; bus.zimm = 5'd1;
    #2 rst = 1'b1;
    #1;
    chk("arst_tohost", 64'(bus.tohost), 64'd0);
    chk("arst_rdata", 64'(bus.csr_rdata), 64'd0);
    chk("arst_rvalid", 64'(bus.csr_rvalid), 64'd0);
    m_tohost = '0; m_mscratch = '0; cyc_base = '0; edges_at_base = '0;
    @(negedge clk);
    bus.csr_we = 1'b0;
    rst = 1'b0;
    chk("arst_no_write", 64'(bus.tohost), 64'd0);
    csr_op("rd_mscr_rst", 1'b1, 3'b010, 12'h340, 32'h0, 5'd0);
    csr_op("rd_cycle_rst", 1'b1, 3'b010, 12'hC00, 32'h0, 5'd0);
    csr_op("rd_cycleh_rst", 1'b1, 3'b010, 12'hC80, 32'h0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
